// File: rtl/freq_display_driver.sv
// Binary-to-BCD display driver: sequential shift-add-3 conversion feeding a
// 4-digit multiplexed common-anode 7-segment display with blanking and overflow.
module freq_display_driver #(
  parameter int BIN_W    = 14,
  parameter int SCAN_DIV = 100000
) (
  input  logic             sysclk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] value_in,
  input  logic             value_valid,
  output logic             busy,
  output logic             overflow,
  output logic [6:0]       cathodes,
  output logic [3:0]       AN
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SH_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t state, state_next;

  logic                   pend_full, pend_full_next;
  logic [BIN_W-1:0]       pend_val;
  logic [BIN_W-1:0]       bin_sr;
  logic [15:0]            bcd;
  logic [15:0]            bcd_adj;
  logic [16+BIN_W-1:0]    shifted;
  logic                   ovf_lat;
  logic [SH_W-1:0]        shift_cnt;
  logic                   busy_next;
  logic [15:0]            disp;
  logic [CNT_W-1:0]       scan_cnt;
  logic [1:0]             digit_idx;
  logic [3:0]             nib;
  logic                   blank;
  logic [6:0]             seg_next;
  logic [3:0]             an_next;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return r;
  endfunction

  function automatic logic exceeds(input logic [BIN_W-1:0] v);
    return (32'(v) > 32'd9999);
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Conversion control: next state, pending slot and busy lookahead
  always_comb begin
    state_next     = state;
    pend_full_next = pend_full;
    case (state)
      IDLE:    if (value_valid || pend_full) state_next = SHIFT;
      SHIFT:   if (shift_cnt == SH_LAST) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // IDLE consumes whatever is waiting; a fresh strobe there beats the slot
    if (state == IDLE) pend_full_next = 1'b0;
    else if (value_valid) pend_full_next = 1'b1;
    // Stay busy across the IDLE hop when another value is already queued
    busy_next = (state_next != IDLE) || pend_full_next;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend_full <= 1'b0;
      busy      <= 1'b0;
      shift_cnt <= '0;
    end else begin
      state     <= state_next;
      pend_full <= pend_full_next;
      busy      <= busy_next;
      shift_cnt <= (state == SHIFT) ? shift_cnt + 1'b1 : '0;
    end
  end

  // Shift-add-3 datapath
  always_comb begin
    bcd_adj = add3(bcd);
    shifted = {bcd_adj, bin_sr} << 1;
  end

  always_ff @(posedge sysclk) begin
    if (state != IDLE && value_valid) pend_val <= value_in;
    case (state)
      IDLE: begin
        bcd <= '0;
        if (value_valid) begin
          bin_sr  <= value_in;
          ovf_lat <= exceeds(value_in);
        end else if (pend_full) begin
          bin_sr  <= pend_val;
          ovf_lat <= exceeds(pend_val);
        end
      end
      SHIFT:   {bcd, bin_sr} <= shifted;
      default: ;
    endcase
  end

  // Display registers change only on COMMIT so a digit never shows a half result
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      disp     <= '0;
      overflow <= 1'b0;
    end else if (state == COMMIT) begin
      disp     <= bcd;
      overflow <= ovf_lat;
    end
  end

  // Scan timing
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= 2'd0;
    end else if (scan_cnt == CNT_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  // Segment selection with leading-zero blanking
  always_comb begin
    nib   = disp[3:0];
    blank = 1'b0;
    case (digit_idx)
      2'd0: nib = disp[3:0];
      2'd1: begin
        nib   = disp[7:4];
        blank = (disp[15:4] == 12'd0);
      end
      2'd2: begin
        nib   = disp[11:8];
        blank = (disp[15:8] == 8'd0);
      end
      default: begin
        nib   = disp[15:12];
        blank = (disp[15:12] == 4'd0);
      end
    endcase
    if (overflow)   seg_next = 7'b0111111;
    else if (blank) seg_next = 7'b1111111;
    else            seg_next = seg_encode(nib);
    an_next = ~(4'b0001 << digit_idx);
  end

  // AN and cathodes share one register stage so they always switch together
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      AN       <= 4'b1111;
      cathodes <= 7'b1111111;
    end else begin
      AN       <= an_next;
      cathodes <= seg_next;
    end
  end

endmodule

// File: tb/tb_freq_display_driver.sv
// Bench for freq_display_driver: per-cycle reference model plus directed literal checks.
module tb_freq_display_driver;

  localparam int BIN_W    = 14;
  localparam int SCAN_DIV = 4;

  logic             sysclk = 1'b0;
  logic             rst_n = 1'b1;
  logic [BIN_W-1:0] value_in = '0;
  logic             value_valid = 1'b0;
  logic             busy, overflow;
  logic [6:0]       cathodes;
  logic [3:0]       AN;

  int checks = 0;
  int failures = 0;

  freq_display_driver #(.BIN_W(BIN_W), .SCAN_DIV(SCAN_DIV)) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .value_in    (value_in),
    .value_valid (value_valid),
    .busy        (busy),
    .overflow    (overflow),
    .cathodes    (cathodes),
    .AN          (AN)
  );

  always #5 sysclk = ~sysclk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int val, input bit ovf, input int idx);
    int p;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (ovf) return 7'b0111111;
    if (idx > 0 && val < p) return 7'b1111111;
    return seg_tab[(val / p) % 10];
  endfunction

  // Reference model: a job runs BIN_W+1 cycles after it starts, a one-deep
  // queue holds the latest strobe seen while busy, scan position from edge count.
  int n_edges, job_age, job_val, pend_val, disp_val;
  bit job_on, pend, disp_ovf;

  always @(posedge sysclk) begin : model
    int idx, sv;
    bit so;
    logic [3:0] exp_an;
    if (!rst_n) begin
      n_edges = 0; job_on = 0; pend = 0; job_age = 0;
      job_val = 0; pend_val = 0; disp_val = 0; disp_ovf = 0;
      #1;
      check("rst_an", AN, 4'b1111);
      check("rst_cath", cathodes, 7'b1111111);
      check("rst_busy", busy, 1'b0);
      check("rst_ovf", overflow, 1'b0);
    end else begin
      idx = (n_edges / SCAN_DIV) % 4;
      n_edges++;
      sv = disp_val;
      so = disp_ovf;
      if (job_on) begin
        if (value_valid) begin
          pend = 1; pend_val = int'(value_in);
        end
        job_age++;
        if (job_age == BIN_W + 1) begin
          disp_val = job_val; disp_ovf = (job_val > 9999); job_on = 0;
        end
      end else if (value_valid) begin
        job_on = 1; job_age = 0; job_val = int'(value_in); pend = 0;
      end else if (pend) begin
        job_on = 1; job_age = 0; job_val = pend_val; pend = 0;
      end
      exp_an = ~(4'b0001 << idx);
      #1;
      check("model_an", AN, exp_an);
      check("model_cath", cathodes, exp_seg(sv, so, idx));
      check("model_busy", busy, job_on || pend);
      check("model_ovf", overflow, disp_ovf);
    end
  end

  task automatic strobe(input int v);
    @(negedge sysclk);
    value_in = BIN_W'(v);
    value_valid = 1'b1;
    @(negedge sysclk);
    value_valid = 1'b0;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge sysclk);
    end
  endtask

  task automatic wait_an(input logic [3:0] a);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (AN == a) begin
        ok = 1;
        break;
      end
      @(negedge sysclk);
    end
    check("wait_an", ok, 1'b1);
  endtask

  task automatic convert(input int v);
    int cnt;
    strobe(v);
    count_busy(cnt);
    check("busy_len", cnt, 15);
    @(negedge sysclk);
  endtask

  initial begin
    int cnt;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge sysclk);
    check("reset_an", AN, 4'b1111);
    check("reset_cath", cathodes, 7'b1111111);
    check("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge sysclk);
    check("release_an", AN, 4'b1110);
    check("release_cath", cathodes, 7'b1000000);

    convert(1234);
    wait_an(4'b1110); check("v1234_d0", cathodes, 7'b0011001);
    wait_an(4'b1101); check("v1234_d1", cathodes, 7'b0110000);
    wait_an(4'b1011); check("v1234_d2", cathodes, 7'b0100100);
    wait_an(4'b0111); check("v1234_d3", cathodes, 7'b1111001);

    convert(7);
    wait_an(4'b1110); check("v7_d0", cathodes, 7'b1111000);
    wait_an(4'b1101); check("v7_d1_blank", cathodes, 7'b1111111);
    wait_an(4'b0111); check("v7_d3_blank", cathodes, 7'b1111111);

    convert(1005);
    wait_an(4'b1101); check("v1005_d1", cathodes, 7'b1000000);
    wait_an(4'b1011); check("v1005_d2", cathodes, 7'b1000000);
    wait_an(4'b0111); check("v1005_d3", cathodes, 7'b1111001);
    wait_an(4'b1110); check("v1005_d0", cathodes, 7'b0010010);

    convert(12000);
    check("ovf_set", overflow, 1'b1);
    wait_an(4'b1011); check("ovf_dash", cathodes, 7'b0111111);

    convert(9999);
    check("ovf_clear", overflow, 1'b0);
    wait_an(4'b0111); check("v9999_d3", cathodes, 7'b0010000);

    // back-to-back strobes at cycles 0, 3 and 5
    @(negedge sysclk);
    value_in = BIN_W'(1111); value_valid = 1'b1;
    @(negedge sysclk); value_valid = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk); value_in = BIN_W'(2222); value_valid = 1'b1;
    @(negedge sysclk); value_valid = 1'b0;
    @(negedge sysclk); value_in = BIN_W'(3333); value_valid = 1'b1;
    @(negedge sysclk); value_valid = 1'b0;
    count_busy(cnt);
    check("b2b_busy_len", cnt, 26);
    @(negedge sysclk);
    wait_an(4'b1110); check("b2b_d0", cathodes, 7'b0110000);
    wait_an(4'b0111); check("b2b_d3", cathodes, 7'b0110000);

    // async reset in the middle of a conversion
    convert(12000);
    strobe(4321);
    repeat (3) @(negedge sysclk);
    check("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_an", AN, 4'b1111);
    check("async_cath", cathodes, 7'b1111111);
    check("async_busy", busy, 1'b0);
    check("async_ovf", overflow, 1'b0);
    repeat (3) @(negedge sysclk);
    rst_n = 1'b1;
    @(negedge sysclk);
    check("post_an", AN, 4'b1110);
    check("post_cath", cathodes, 7'b1000000);
    check("post_busy", busy, 1'b0);
    repeat (20) @(negedge sysclk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/freq_display_driver.md
Name: freq_display_driver

Overview:
- Downstream display stage for the frequency measurement block.
- Accepts a binary measured count and converts it to four BCD digits with a sequential shift-add-3 converter.
- Time-multiplexes the digits onto a 4-digit common-anode 7-segment display.
- Provides leading-zero blanking and an overflow indication.

Parameters:
BIN_W, 14, width of value_in; values 0..9999 display normally, larger values flag overflow
SCAN_DIV, 100000, sysclk cycles each digit stays enabled (1 kHz digit rate at 100 MHz)

Ports:
sysclk  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
value_in  input  BIN_W  binary count to display
value_valid  input  1  single-cycle strobe; value_in sampled when high
busy  output  1  conversion in progress
overflow  output  1  currently displayed value exceeds 9999
cathodes  output  7  segments {g,f,e,d,c,b,a}, active-low
AN  output  4  digit enables, active-low; AN[0] = units (rightmost)

Behaviour:
- Reset (async, rst_n=0):
  - AN=4'b1111, cathodes=7'b1111111, busy=0, overflow=0.
  - Displayed digits = 0,0,0,0; pending slot empty; scan counter=0; digit index=0.
- All outputs are registered.
- First rising edge after rst_n rises: AN=4'b1110, showing "0" on the units digit.
- Conversion FSM states:
  - IDLE: value_valid=1 (or pending slot full) -> latch value into shift register, clear BCD accumulator, go to SHIFT; busy=1 from the next cycle.
  - SHIFT: BIN_W cycles. Each cycle: add 3 to any BCD nibble >=5, then shift {bcd,bin} left by 1. Go to COMMIT after the BIN_W-th shift.
  - COMMIT: one cycle. Copy the 4 BCD nibbles to the display registers atomically. Set overflow = (latched value > 9999). Return to IDLE; busy=0 the cycle after COMMIT.
- Latency: value_valid at cycle 0 -> display registers updated at cycle BIN_W+2. With the default, busy is high for 15 cycles.
- value_valid during SHIFT/COMMIT:
  - Value goes into the one-deep pending slot; a later strobe overwrites it (last one wins).
  - IDLE services the pending slot before returning to wait.
- value_valid in the same cycle the FSM returns to IDLE with the pending slot full: the new value_in wins and the pending slot is cleared.
- Overflow: the BCD result is ignored; all four digits show '-' (7'b0111111).
- Leading-zero blanking:
  - Digit k (k=1..3) is blank (7'b1111111) when it and all higher digits are 0.
  - Units digit is never blanked.
  - Blanking does not apply in overflow.
- Scan:
  - Counter counts 0..SCAN_DIV-1, then wraps.
  - On wrap, digit index increments modulo 4 (0->1->2->3->0).
  - AN = one-hot-low of the digit index.
  - cathodes = encoding of the selected digit, updated in the same cycle as AN (no ghosting cycle).
  - Display registers change only in COMMIT; the scan never pauses during conversion.
- Segment encoding (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset mid-conversion: the FSM aborts to IDLE, pending slot is cleared, all outputs take their reset values immediately.

Test Plan:
- Reset: hold rst_n=0 -> AN=1111, cathodes=1111111, busy=0, overflow=0. Release -> next edge AN=1110, cathodes=1000000.
- Normal value (SCAN_DIV=4): value_valid with 1234 -> busy=1 for 15 cycles. Then scan shows:
  - AN=1110 cathodes=0011001 (4)
  - AN=1101 0110000 (3)
  - AN=1011 0100100 (2)
  - AN=0111 1111001 (1)
  - each held 4 cycles, then wraps.
- Leading-zero blanking: value 7 -> units digit 1111000; digits 1..3 show 1111111 while their AN is active. Value 1005 -> digits 5,0,0,1, none blanked.
- Overflow: value 12000 -> overflow=1, all four digits 0111111. A subsequent value 9999 clears overflow and shows 0010000 on every digit.
- Back-to-back strobes: 1111, then 2222 at cycle 3, then 3333 at cycle 5 -> busy stays high through two conversions; 2222 is never displayed; final display 3333.
- Async reset during SHIFT (value 4321) -> outputs return to reset values asynchronously; after release the display shows "0" and busy=0.
